line_request_arbiter: RTL and testbench
=======================================

Name: line_request_arbiter

Overview:
- Sequencer and arbiter in front of the Bresenham line drawer.
- Accepts line commands (endpoints plus colour) from two requesters, for example the draw path and the erase path, and grants them round-robin.
- Range-checks each accepted command, launches the drawer with a one-cycle start pulse and holds its endpoint inputs stable until the drawer reports done.
- Returns a per-requester completion response with a status code, and guards every launch with a timeout.

Parameters:
- COORD_W, 11, width of each coordinate, matching the drawer's endpoint and pixel ports.
- MAX_X, 640, exclusive upper bound on x coordinates (screen width).
- MAX_Y, 480, exclusive upper bound on y coordinates (screen height).
- TIMEOUT, 2047, WAIT-state cycle limit before abort; 0 disables the timeout. Counter width is 12 bits.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  2  bit i: requester i presents a command.
- req_ready  out  2  bit i: command i accepted on this edge. Combinational; at most one bit high.
- req_pts  in  8*COORD_W  packed {r1:{x0,y0,x1,y1}, r0:{x0,y0,x1,y1}}; x0 of each requester is in its upper bits.
- req_color  in  2  bit i: colour for requester i.
- rsp_valid  out  2  bit i: one-cycle completion pulse to requester i.
- rsp_code  out  2  status, valid with rsp_valid: 00 drawn, 01 out of range, 10 timeout.
- ld_start  out  1  one-cycle launch pulse to the drawer.
- ld_x0, ld_y0, ld_x1, ld_y1  out  COORD_W each  latched endpoints; stable from LAUNCH through WAIT.
- ld_color  out  1  latched colour.
- ld_done  in  1  drawer has finished the current line (level or pulse).
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  requester owning the current command.

Behaviour:
- States: IDLE, CHECK, LAUNCH, WAIT, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_code=00, ld_start=0, ld_x0/ld_y0/ld_x1/ld_y1=0, ld_color=0, busy=0, grant_id=0, last_grant=1 (so requester 0 wins the first tie), timeout counter=0.
- Reset mid-operation: the in-flight command is dropped with no response. The requester must keep or re-assert valid to retry.

Arbitration and handshake (IDLE):
- Winner is the single valid requester. If both are valid, the winner is the one not equal to last_grant.
- req_ready[winner] is high combinationally during IDLE only.
- Transfer occurs on an edge where valid && ready. On that edge: latch the winner's points, colour and id, then go to CHECK.
- Requester rules: once valid is raised, keep valid and payload stable until ready; valid must not be withdrawn.
- req_pts and req_color of a non-granted requester are ignored.

CHECK (1 cycle):
- If any latched x >= MAX_X or any y >= MAX_Y: go to RESP with code 01. The drawer is never started.
- Otherwise go to LAUNCH.
- Zero-length lines (x0==x1 and y0==y1) are legal and are launched.

LAUNCH (1 cycle):
- ld_start=1. Clear the timeout counter. Go to WAIT.

WAIT:
- ld_done is sampled only in WAIT; ld_done in any other state is ignored.
- ld_done=1: go to RESP with code 00.
- Otherwise the counter increments each cycle. When the counter == TIMEOUT (and TIMEOUT != 0): go to RESP with code 10.
- If ld_done and the timeout occur in the same cycle, ld_done wins (code 00).

RESP (1 cycle):
- rsp_valid[grant_id]=1 with rsp_code.
- last_grant <= grant_id.
- Go to IDLE. The next acceptance is possible on the following edge.

Latency:
- Accept at edge E0. ld_start is high in cycle E1–E2.
- A reject response is high in cycle E1–E2.
- A done response is high in the cycle after the edge at which ld_done was sampled.

Outputs:
- All outputs are registered or decoded from state, except req_ready.
- ld_* outputs hold their last values in IDLE.

Test Plan:
- Reset, then r0 valid with (0,0)->(100,20), colour 1 -> req_ready[0] high in the first IDLE cycle; ld_start high exactly one cycle, 2 cycles after accept; ld_x1=100, ld_y1=20, ld_color=1. Drawer done asserted 30 cycles later -> rsp_valid[0] one cycle, code 00, busy low the next cycle.
- Both requesters valid continuously, each with a legal line, done returned after 5 cycles -> grants alternate 0,1,0,1 across 4 commands; req_ready is never high for both bits.
- r1 command (10,10)->(640,5) -> rsp_valid[1] with code 01 two cycles after accept; ld_start never asserted.
- TIMEOUT=8 and drawer done never asserted -> rsp_code 10 exactly 9 cycles after ld_start; the next command is accepted afterwards.
- Drawer done held high in IDLE and CHECK -> ignored. Drawer done coincident with timeout expiry -> code 00.
- reset asserted mid-WAIT, asynchronously between edges -> busy, ld_start and rsp_valid are 0 immediately with no response pulse; a still-valid r0 is re-accepted after reset deasserts.

Source files
------------

// File: rtl/line_request_arbiter.sv
// ---------------------------------------------------------------------------
// line_request_arbiter
//
// Sequencer and round-robin arbiter in front of the Bresenham line drawer.
// Two requesters (e.g. draw path and erase path) present line commands; the
// winner is latched, range-checked, launched on the drawer with a one-cycle
// start pulse, and answered with a one-cycle completion response carrying a
// status code. Every launch is guarded by a WAIT-state timeout.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-high reset
//   req_valid  [1:0] requester i presents a command
//   req_ready  [1:0] command i accepted on this edge (combinational, one-hot)
//   req_pts    {r1:{x0,y0,x1,y1}, r0:{x0,y0,x1,y1}}
//   req_color  [1:0] colour per requester
//   rsp_valid  [1:0] one-cycle completion pulse per requester
//   rsp_code   00 drawn, 01 out of range, 10 timeout
//   ld_start   one-cycle launch pulse to the drawer
//   ld_x0..y1  latched endpoints, stable from LAUNCH through WAIT
//   ld_color   latched colour
//   ld_done    drawer finished (level or pulse), sampled only in WAIT
//   busy       high whenever the sequencer is not IDLE
//   grant_id   requester owning the current command
//   dbg_state  current sequencer state, for observation
// ---------------------------------------------------------------------------
module line_request_arbiter #(
    parameter int COORD_W = 11,
    parameter int MAX_X   = 640,
    parameter int MAX_Y   = 480,
    parameter int TIMEOUT = 2047
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [8*COORD_W-1:0] req_pts,
    input  logic [1:0]           req_color,
    output logic [1:0]           rsp_valid,
    output logic [1:0]           rsp_code,
    output logic                 ld_start,
    output logic [COORD_W-1:0]   ld_x0,
    output logic [COORD_W-1:0]   ld_y0,
    output logic [COORD_W-1:0]   ld_x1,
    output logic [COORD_W-1:0]   ld_y1,
    output logic                 ld_color,
    input  logic                 ld_done,
    output logic                 busy,
    output logic                 grant_id,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0]         CODE_DRAWN   = 2'b00;
    localparam logic [1:0]         CODE_RANGE   = 2'b01;
    localparam logic [1:0]         CODE_TIMEOUT = 2'b10;
    localparam logic [COORD_W-1:0] LP_MAX_X     = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] LP_MAX_Y     = COORD_W'(MAX_Y);
    localparam logic [11:0]        LP_TIMEOUT   = 12'(TIMEOUT);
    localparam bit                 LP_TO_EN     = (TIMEOUT != 0);

    state_t               r_state;
    logic [1:0]           r_rsp_valid;
    logic [1:0]           r_rsp_code;
    logic                 r_ld_start;
    logic [COORD_W-1:0]   r_x0, r_y0, r_x1, r_y1;
    logic                 r_color;
    logic                 r_grant;
    logic                 r_last_grant;
    logic [11:0]          r_cnt;

    logic                 w_win;
    logic [4*COORD_W-1:0] w_sel;
    logic                 w_oor;
    logic [11:0]          w_cnt_inc;

    // Handshake: a command transfers on a clock edge where req_valid[i] and
    // req_ready[i] are both high. Requesters hold valid and payload stable
    // until that edge; ready is offered only in IDLE and only to the winner.
    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_win     = (req_valid[0] & req_valid[1]) ? ~r_last_grant : req_valid[1];
        req_ready = 2'b00;
        if ((r_state == S_IDLE) && (req_valid != 2'b00)) begin
            req_ready = w_win ? 2'b10 : 2'b01;
        end
    end

    assign w_sel = w_win ? req_pts[8*COORD_W-1:4*COORD_W] : req_pts[4*COORD_W-1:0];

    assign w_oor = (r_x0 >= LP_MAX_X) | (r_x1 >= LP_MAX_X) |
                   (r_y0 >= LP_MAX_Y) | (r_y1 >= LP_MAX_Y);

    // Timeout compares the post-increment count, so WAIT lasts exactly
    // TIMEOUT cycles before the abort.
    assign w_cnt_inc = r_cnt + 12'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rsp_valid  <= 2'b00;
            r_rsp_code   <= CODE_DRAWN;
            r_ld_start   <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_x1         <= '0;
            r_y1         <= '0;
            r_color      <= 1'b0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 12'd0;
        end else begin
            r_ld_start  <= 1'b0;
            r_rsp_valid <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        r_x0    <= w_sel[4*COORD_W-1:3*COORD_W];
                        r_y0    <= w_sel[3*COORD_W-1:2*COORD_W];
                        r_x1    <= w_sel[2*COORD_W-1:COORD_W];
                        r_y1    <= w_sel[COORD_W-1:0];
                        r_color <= req_color[w_win];
                        r_grant <= w_win;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_oor) begin
                        r_rsp_code  <= CODE_RANGE;
                        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_state     <= S_RESP;
                    end else begin
                        r_ld_start <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= 12'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a coincident timeout.
                    if (ld_done) begin
                        r_rsp_code  <= CODE_DRAWN;
                        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_state     <= S_RESP;
                    end else if (LP_TO_EN && (w_cnt_inc == LP_TIMEOUT)) begin
                        r_rsp_code  <= CODE_TIMEOUT;
                        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_state     <= S_RESP;
                    end
                    r_cnt <= w_cnt_inc;
                end
                S_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_code  = r_rsp_code;
    assign ld_start  = r_ld_start;
    assign ld_x0     = r_x0;
    assign ld_y0     = r_y0;
    assign ld_x1     = r_x1;
    assign ld_y1     = r_y1;
    assign ld_color  = r_color;
    assign grant_id  = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_line_request_arbiter.sv
module tb_line_request_arbiter;
  localparam int CW    = 11;
  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;
  localparam int TO    = 40;
  localparam int NEVER = 100000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_color = '0, rsp_valid, rsp_code;
  logic [8*CW-1:0] req_pts = '0;
  logic ld_start, ld_color, busy, grant_id;
  logic ld_done = 1'b0;
  logic [CW-1:0] ld_x0, ld_y0, ld_x1, ld_y1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  line_request_arbiter #(.COORD_W(CW), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pts(req_pts), .req_color(req_color), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .ld_start(ld_start), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_color(ld_color), .ld_done(ld_done), .busy(busy), .grant_id(grant_id),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [4*CW:0] exp_q[$];   // {x0,y0,x1,y1,color} of accepted legal commands

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- requester / drawer stimulus state ----------------
  bit            q_v[2];
  logic [4*CW-1:0] q_p[2];
  logic          q_c[2];
  bit            refill[2];
  bit            auto_gen = 0;
  int            noise_mode = 0;   // ld_done outside WAIT: 0 low, 1 random, 2 high
  int            force_d = -1;     // directed done delay (WAIT cycle index), -1 random
  bit            g_log[$];         // observed grant_id per accepted command

  // ---------------- transaction-level reference model ----------------
  // A command accepted at the end of an IDLE cycle occupies k = 1 (check),
  // then either responds at k = 2 (range error) or starts the drawer at k = 2
  // and waits from k = 3; the response lands one cycle after done is seen or
  // after TO waiting cycles, and the next cycle is idle again.
  bit          m_active = 0;
  int          m_k = 0;
  int          m_rk = 0;           // response cycle index, 0 = not yet known
  bit          m_id = 0;
  bit          m_ok = 0;
  bit          m_last = 1;
  logic [1:0]  m_code = 0;
  int          m_d = NEVER;
  logic [4*CW:0] m_cur = '0;

  function automatic logic [4*CW-1:0] line(input int x0, input int y0, input int x1, input int y1);
    return {CW'(x0), CW'(y0), CW'(x1), CW'(y1)};
  endfunction

  function automatic logic [4*CW-1:0] make_line(input bit legal);
    logic [CW-1:0] c[4];
    for (int i = 0; i < 4; i++) begin
      int lim;
      lim = (i % 2 == 0) ? MAX_X : MAX_Y;
      case (legal ? 5 : $urandom_range(0, 19))
        0: c[i] = CW'(lim - 1);
        1: c[i] = CW'(lim);
        2: c[i] = CW'($urandom_range(lim, 2047));
        3: c[i] = '0;
        default: c[i] = CW'($urandom_range(0, lim - 1));
      endcase
    end
    return {c[0], c[1], c[2], c[3]};
  endfunction

  function automatic bit in_range(input logic [4*CW-1:0] p);
    return (int'(p[4*CW-1 -: CW]) < MAX_X) && (int'(p[3*CW-1 -: CW]) < MAX_Y) &&
           (int'(p[2*CW-1 -: CW]) < MAX_X) && (int'(p[CW-1 -: CW]) < MAX_Y);
  endfunction

  function automatic int pick_delay();
    if (force_d >= 0) return force_d;
    case ($urandom_range(0, 5))
      0: return TO;          // coincident with timeout: done wins
      1: return NEVER;       // timeout
      2: return TO - 1;
      default: return $urandom_range(1, 12);
    endcase
  endfunction

  // ---------------- one clock cycle: drive, compare, advance model ----------------
  task automatic cycle_body();
    bit in_wait, win, e_start;
    logic [1:0] e_ready, e_rsp;
    for (int i = 0; i < 2; i++)
      if (!q_v[i] && (refill[i] || (auto_gen && $urandom_range(0, 3) == 0))) begin
        q_v[i] = 1;
        q_p[i] = make_line(refill[i]);
        q_c[i] = 1'($urandom_range(0, 1));
      end
    in_wait = m_active && m_ok && (m_rk == 0) && (m_k >= 3);
    if (in_wait) ld_done = ((m_k - 2) >= m_d);
    else ld_done = (noise_mode == 2) || ((noise_mode == 1) && ($urandom_range(0, 3) == 0));
    req_valid = {q_v[1], q_v[0]};
    req_pts   = {q_p[1], q_p[0]};
    req_color = {q_c[1], q_c[0]};
    #1;
    win = (q_v[0] && q_v[1]) ? !m_last : q_v[1];
    e_ready = 2'b00;
    if (!m_active && (q_v[0] || q_v[1])) e_ready[win] = 1'b1;
    check("req_ready", req_ready, e_ready);
    check("busy", busy, m_active);
    if (m_active) check("grant_id", grant_id, m_id);
    if (m_active && m_k == 1) g_log.push_back(grant_id);
    e_start = m_active && m_ok && (m_k == 2);
    check("ld_start", ld_start, e_start);
    if (e_start) begin
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else m_cur = exp_q.pop_front();
      m_d = pick_delay();
    end
    if (m_active && m_ok && m_k >= 2 && (m_rk == 0 || m_k < m_rk))
      check("ld_hold", {ld_x0, ld_y0, ld_x1, ld_y1, ld_color}, m_cur);
    e_rsp = (m_active && m_k == m_rk) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    check("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp != 2'b00) check("rsp_code", rsp_code, m_code);
    // advance to next cycle
    if (!m_active) begin
      if (q_v[0] || q_v[1]) begin
        m_active = 1; m_k = 1; m_id = win;
        m_ok = in_range(q_p[win]);
        if (m_ok) begin m_rk = 0; exp_q.push_back({q_p[win], q_c[win]}); end
        else begin m_rk = 2; m_code = 2'b01; end
        q_v[win] = 0;
      end
    end else if (m_k == m_rk) begin
      m_active = 0; m_last = m_id;
    end else begin
      if (in_wait) begin
        if (ld_done) begin m_rk = m_k + 1; m_code = 2'b00; end
        else if (TO != 0 && (m_k - 2) == TO) begin m_rk = m_k + 1; m_code = 2'b10; end
      end
      m_k++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle_body();
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && (m_active || q_v[0] || q_v[1]); n++) step();
    check("drain_bound", {62'd0, m_active, q_v[0] | q_v[1]}, 64'd0);
  endtask

  // Asserts reset between edges, checks immediate clearing, releases it on a
  // falling edge and runs the first idle cycle.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_start", ld_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    check("rst_rsp_hold", rsp_valid, 0);
    reset = 1'b0;
    check("rst_ld_pts", {ld_x0, ld_y0, ld_x1, ld_y1, ld_color}, 0);
    check("rst_grant", grant_id, 0);
    check("rst_code", rsp_code, 0);
    m_active = 0; m_k = 0; m_rk = 0; m_last = 1; m_d = NEVER;
    exp_q.delete();
    cycle_body();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    #2;
    do_reset();

    // Basic draw, done 30 cycles into WAIT.
    q_v[0] = 1; q_p[0] = line(0, 0, 100, 20); q_c[0] = 1; force_d = 30;
    drain(80);

    // Alternating grants with both requesters continuously valid.
    do_reset();
    g_log.delete();
    refill[0] = 1; refill[1] = 1; force_d = 5;
    for (int n = 0; n < 200 && g_log.size() < 4; n++) step();
    refill[0] = 0; refill[1] = 0;
    drain(80);
    for (int i = 0; i < 4; i++)
      check("alt_grant", (i < g_log.size()) ? 64'(g_log[i]) : 64'd2, 64'(i % 2));

    // Range reject from requester 1.
    q_v[1] = 1; q_p[1] = line(10, 10, 640, 5); q_c[1] = 0;
    drain(20);
    // Boundary: largest legal coordinates, and a zero-length line.
    q_v[0] = 1; q_p[0] = line(639, 479, 639, 479); q_c[0] = 0; force_d = 2;
    drain(30);
    q_v[1] = 1; q_p[1] = line(7, 480, 7, 3); q_c[1] = 1;
    drain(20);

    // Timeout, then a following command is still accepted.
    q_v[0] = 1; q_p[0] = line(1, 2, 3, 4); q_c[0] = 1; force_d = NEVER;
    drain(TO + 20);
    q_v[0] = 1; q_p[0] = line(4, 3, 2, 1); q_c[0] = 0; force_d = 4;
    drain(30);

    // Done held high outside WAIT, and done coincident with timeout.
    noise_mode = 2; force_d = TO;
    repeat (3) step();
    q_v[1] = 1; q_p[1] = line(20, 30, 40, 50); q_c[1] = 1;
    drain(TO + 20);
    noise_mode = 0;

    // Reset in the middle of WAIT; requester 0 keeps its command valid.
    q_v[0] = 1; q_p[0] = line(5, 5, 50, 60); q_c[0] = 0; force_d = NEVER;
    for (int n = 0; n < 30 && !(m_active && m_k == 6); n++) step();
    check("reached_wait", {m_active, m_ok}, 2'b11);
    #2;
    q_v[0] = 1;
    force_d = 3;
    do_reset();
    drain(30);

    // Randomized traffic.
    force_d = -1; noise_mode = 1; auto_gen = 1;
    repeat (3000) step();
    auto_gen = 0;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
